// File: rtl/mux4p1_tdm_pkg.sv
// mux4p1_tdm_pkg: shared lane count, select width and lane index constants.
package mux4p1_tdm_pkg;
    localparam int LANES = 4;
    localparam int SEL_W = 2;
    typedef logic [SEL_W-1:0] sel_t;
    localparam sel_t LANE0 = 2'd0;
    localparam sel_t LANE1 = 2'd1;
    localparam sel_t LANE2 = 2'd2;
    localparam sel_t LANE3 = 2'd3;
endpackage

// File: rtl/mux4p1_sel.sv
// mux4p1_sel: combinational 4:1 lane selector.
module mux4p1_sel
    import mux4p1_tdm_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [LANES*W-1:0] lanes,
    input  sel_t               sel,
    output logic [W-1:0]       lane
);
    assign lane = lanes[int'(sel)*W +: W];
endmodule

// File: rtl/mux4p1_tdm.sv
// mux4p1_tdm: time-division 4:1 serializer, one captured lane per enabled cycle.
module mux4p1_tdm
    import mux4p1_tdm_pkg::*;
#(
    parameter int W = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [LANES*W-1:0] lanes_in,
    output logic [W-1:0]       data_out,
    output sel_t               sel_out,
    output logic               frame_start,
    output logic               out_valid
);
    sel_t               cnt;
    logic [LANES*W-1:0] shadow;
    logic [W-1:0]       shadow_lane;

    mux4p1_sel #(.W(W)) u_sel (
        .lanes(shadow),
        .sel  (cnt),
        .lane (shadow_lane)
    );

    // lane 0 bypasses the shadow so a frame starts without extra latency
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= LANE0;
            shadow      <= '0;
            data_out    <= '0;
            sel_out     <= LANE0;
            frame_start <= 1'b0;
            out_valid   <= 1'b0;
        end else if (en) begin
            if (cnt == LANE0) shadow <= lanes_in;
            data_out    <= (cnt == LANE0) ? lanes_in[W-1:0] : shadow_lane;
            frame_start <= (cnt == LANE0);
            sel_out     <= cnt;
            out_valid   <= 1'b1;
            cnt         <= cnt + 2'd1;
        end else begin
            frame_start <= 1'b0;
            out_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux4p1_tdm.sv
// tb_mux4p1_tdm: directed checks of the 4:1 serializer at W=1 and W=8.
module tb_mux4p1_tdm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [3:0]  lanes1 = 4'b1111;
    logic [31:0] lanes8 = 32'hffff_ffff;
    logic        d1, fs1, ov1, fs8, ov8;
    logic [1:0]  s1, s8;
    logic [7:0]  d8;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux4p1_tdm #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .lanes_in(lanes1),
        .data_out(d1), .sel_out(s1), .frame_start(fs1), .out_valid(ov1)
    );
    mux4p1_tdm #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .lanes_in(lanes8),
        .data_out(d8), .sel_out(s8), .frame_start(fs8), .out_valid(ov8)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({s1, d1, fs1, ov1} !== 5'b0 || {s8, d8, fs8, ov8} !== 12'h0) begin
                failures++;
                $display("FAIL reset cyc%0d w1={sel,d,fs,ov}=%b w8=%h expected all zero", i, {s1, d1, fs1, ov1}, {s8, d8, fs8, ov8});
            end
        end
    endtask

    task automatic test_frame();
        logic [4:0] exp [4] = '{5'b00_0_11, 5'b01_1_01, 5'b10_0_01, 5'b11_1_01};
        logic [3:0] recon;
        rst = 1'b0;
        lanes1 = 4'b1010;
        lanes8 = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 8; i++) begin
            step();
            recon[s1] = d1;
            checks++;
            if ({s1, d1, fs1, ov1} !== exp[i%4]) begin
                failures++;
                $display("FAIL frame beat%0d got %b expected %b", i, {s1, d1, fs1, ov1}, exp[i%4]);
            end
            checks++;
            if ({s8, d8, fs8, ov8} !== {2'(i%4), 8'(8'h11*(i%4+1)), i%4 == 0, 1'b1}) begin
                failures++;
                $display("FAIL w8 beat%0d got sel=%0d d=%h fs=%b ov=%b expected sel=%0d d=%h", i, s8, d8, fs8, ov8, i%4, 8'(8'h11*(i%4+1)));
            end
            if (i % 4 == 3) begin
                checks++;
                if (recon !== 4'b1010) begin
                    failures++;
                    $display("FAIL demux_rebuild got %b expected 1010", recon);
                end
            end
        end
    endtask

    task automatic test_mid_change();
        logic [4:0] exp [8] = '{5'b00_0_11, 5'b01_1_01, 5'b10_0_01, 5'b11_1_01,
                                5'b00_1_11, 5'b01_0_01, 5'b10_1_01, 5'b11_0_01};
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 1) lanes1 = 4'b0101;
            checks++;
            if ({s1, d1, fs1, ov1} !== exp[i]) begin
                failures++;
                $display("FAIL mid_change beat%0d got %b expected %b", i, {s1, d1, fs1, ov1}, exp[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [4:0] exp [6] = '{5'b00_1_11, 5'b01_0_01, 5'b01_0_00, 5'b01_0_00, 5'b10_1_01, 5'b11_0_01};
        for (int i = 0; i < 6; i++) begin
            en = !(i == 2 || i == 3);
            if (i == 2) lanes1 = 4'b1010;
            step();
            checks++;
            if ({s1, d1, fs1, ov1} !== exp[i]) begin
                failures++;
                $display("FAIL stall beat%0d got %b expected %b", i, {s1, d1, fs1, ov1}, exp[i]);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp [8] = '{5'b00_0_11, 5'b01_1_01, 5'b10_0_01, 5'b00_0_00,
                                5'b00_0_11, 5'b01_1_01, 5'b10_1_01, 5'b11_0_01};
        for (int i = 0; i < 8; i++) begin
            rst = (i == 3);
            if (i == 3) lanes1 = 4'b0110;
            step();
            checks++;
            if ({s1, d1, fs1, ov1} !== exp[i]) begin
                failures++;
                $display("FAIL reset_mid beat%0d got %b expected %b", i, {s1, d1, fs1, ov1}, exp[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_w8();
        logic [7:0] exp [4] = '{8'hef, 8'hbe, 8'had, 8'hde};
        lanes8 = {8'hde, 8'had, 8'hbe, 8'hef};
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) lanes8 = 32'h0;
            checks++;
            if (d8 !== exp[i] || s8 !== 2'(i) || ov8 !== 1'b1) begin
                failures++;
                $display("FAIL w8_frame beat%0d got sel=%0d d=%h ov=%b expected sel=%0d d=%h ov=1", i, s8, d8, ov8, i, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_mid_change();
        test_stall();
        test_reset_mid();
        test_w8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
